icache_refill_ctrl: RTL

- Sequences line refills of the instruction cache from the backing instruction memory on a cache miss.
- Fetches LINE_WORDS consecutive 32-bit words, critical word first with wrap-around, and writes each word into the cache data array.
- Forwards the critical word to fetch early and marks the line valid once the fill completes.
- Aborts cleanly on a pipeline flush (branch redirect); an aborted line is never marked valid.

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_refill_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/icache_pkg.sv
// Shared types and helpers for the instruction-cache refill logic.
package icache_pkg;

    localparam int ICACHE_ADDR_W     = 32;
    localparam int ICACHE_LINE_WORDS = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } refill_state_e;

    // Clears the word-offset and byte-offset bits, leaving the line base.
    function automatic logic [ICACHE_ADDR_W-1:0] line_base_of(
        input logic [ICACHE_ADDR_W-1:0] addr,
        input int unsigned              off_w
    );
        logic [ICACHE_ADDR_W-1:0] mask;
        mask = {ICACHE_ADDR_W{1'b1}} << (off_w + 2);
        return addr & mask;
    endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill sequencer: critical word first with wrap,
// early critical-word forwarding, tag write on completion, clean flush abort.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int  ADDR_W     = ICACHE_ADDR_W,
    parameter int  LINE_WORDS = ICACHE_LINE_WORDS,
    localparam int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_valid,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              miss_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_line,
    output logic [OFF_W-1:0]  fill_word,
    output logic [31:0]       fill_data,
    output logic              fill_tag_we,
    output logic              crit_valid,
    output logic [31:0]       crit_data,
    output logic              busy
);

    localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(LINE_WORDS - 1);

    refill_state_e     state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [OFF_W-1:0]  crit_off_q, crit_off_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;

    // Word index of the current beat; OFF_W-bit addition wraps inside the line.
    logic [OFF_W-1:0]  word_idx;
    logic [ADDR_W-1:0] word_addr;

    assign word_idx  = crit_off_q + cnt_q;
    assign word_addr = line_base_q + ADDR_W'({word_idx, 2'b00});

    // Next-state logic: accept a miss, then alternate request/response per word.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        crit_off_d  = crit_off_q;
        line_base_d = line_base_q;
        case (state_q)
            ST_IDLE: begin
                if (miss_valid && !flush) begin
                    state_d     = ST_REQ;
                    line_base_d = line_base_of(miss_addr, OFF_W);
                    crit_off_d  = miss_addr[OFF_W+1:2];
                    cnt_d       = '0;
                end
            end
            ST_REQ: begin
                // A flush here means no request is in flight, so just drop the line.
                state_d = flush ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (flush) begin
                    // If the response lands with the flush it is consumed and discarded;
                    // otherwise it is still owed and must be drained.
                    state_d = mem_rvalid ? ST_IDLE : ST_DRAIN;
                end else if (mem_rvalid) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DRAIN: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                // The line is complete; the tag write goes out even under flush.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode; data-carrying outputs are held at zero when not qualified.
    always_comb begin
        miss_ready  = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        fill_we     = 1'b0;
        fill_word   = '0;
        fill_data   = '0;
        fill_tag_we = 1'b0;
        crit_valid  = 1'b0;
        crit_data   = '0;
        busy        = (state_q != ST_IDLE);
        fill_line   = busy ? line_base_q : '0;
        case (state_q)
            ST_IDLE: begin
                miss_ready = !flush;
            end
            ST_REQ: begin
                if (!flush) begin
                    mem_req  = 1'b1;
                    mem_addr = word_addr;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid && !flush) begin
                    fill_we   = 1'b1;
                    fill_word = word_idx;
                    fill_data = mem_rdata;
                    if (cnt_q == '0) begin
                        crit_valid = 1'b1;
                        crit_data  = mem_rdata;
                    end
                end
            end
            ST_DONE: begin
                fill_tag_we = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State and line-context registers; reset abandons any partial line untagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            crit_off_q  <= '0;
            line_base_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crit_off_q  <= crit_off_d;
            line_base_q <= line_base_d;
        end
    end

endmodule
